// File: rtl/sprite_collide.sv
// sprite_collide: frame-synchronous player/monster collision detector.
//   Watches per-pixel sprite outputs during the scan, counts opaque overlap
//   pixels per monster, and reports at most one hit event per frame, followed
//   by an optional invincibility cooldown.
// Latency: overlap pixels are counted one cycle after the beam (stage S1);
//   hit and its outputs appear the cycle after the frame pulse.
// Backpressure: none; the block is a pure observer and never stalls the scan.
// Ports:
//   clk, rst, replay            clock, synchronous active-high reset / restart
//   frame, de, sx, sy           frame pulse, visible-area flag, beam position
//   player_drawing/pix          player sprite drawing flag and palette index
//   mon_drawing/mon_pix         per-monster drawing flags and packed indices
//   hit, hit_mask, hit_x/y      hit pulse, qualifying monsters, first hit coords
//   invincible, hit_count       cooldown flag, saturating accepted-hit count
module sprite_collide #(
  parameter int CORDW           = 16,
  parameter int NUM_MON         = 4,
  parameter int COLR_BITS       = 4,
  parameter int TRANS_IDX       = 0,
  parameter int MIN_OVERLAP     = 4,
  parameter int COOLDOWN_FRAMES = 60
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           replay,
  input  logic                           frame,
  input  logic                           de,
  input  logic signed [CORDW-1:0]        sx,
  input  logic signed [CORDW-1:0]        sy,
  input  logic                           player_drawing,
  input  logic [COLR_BITS-1:0]           player_pix,
  input  logic [NUM_MON-1:0]             mon_drawing,
  input  logic [NUM_MON*COLR_BITS-1:0]   mon_pix,
  output logic                           hit,
  output logic [NUM_MON-1:0]             hit_mask,
  output logic signed [CORDW-1:0]        hit_x,
  output logic signed [CORDW-1:0]        hit_y,
  output logic                           invincible,
  output logic [7:0]                     hit_count
);

  localparam int CW = $clog2(MIN_OVERLAP + 1);
  localparam int DW = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam logic [CW-1:0]        CNT_MAX   = CW'(MIN_OVERLAP);
  localparam logic [COLR_BITS-1:0] TRANS     = COLR_BITS'(TRANS_IDX);
  localparam logic [DW-1:0]        COOL_INIT = DW'(COOLDOWN_FRAMES);

  typedef enum logic [1:0] {IDLE, ARMED, COOLDOWN} state_t;

  state_t                  state, state_nxt;
  logic                    clr;
  logic [NUM_MON-1:0]      ov;
  logic [NUM_MON-1:0]      s1_ov;
  logic signed [CORDW-1:0] s1_x, s1_y;
  logic [CW-1:0]           cnt     [NUM_MON];
  logic [CW-1:0]           cnt_upd [NUM_MON];
  logic [NUM_MON-1:0]      qual;
  logic                    cand_vld;
  logic signed [CORDW-1:0] cand_x, cand_y;
  logic signed [CORDW-1:0] eval_x, eval_y;
  logic [DW-1:0]           cool, cool_nxt;
  logic                    accept;

  assign clr = rst | replay;

  // Opaque overlap of the player with each monster at the current beam pixel.
  always_comb begin
    ov = '0;
    for (int i = 0; i < NUM_MON; i++) begin
      ov[i] = de & player_drawing & (player_pix != TRANS) & mon_drawing[i]
            & (mon_pix[i*COLR_BITS +: COLR_BITS] != TRANS);
    end
  end

  // Counts as they stand after this cycle's S1 contribution; the frame
  // evaluation looks at these so the last visible pixel is never lost.
  always_comb begin
    qual = '0;
    for (int i = 0; i < NUM_MON; i++) begin
      cnt_upd[i] = cnt[i];
      if (s1_ov[i] && (cnt[i] != CNT_MAX)) cnt_upd[i] = cnt[i] + CW'(1);
      qual[i] = (cnt_upd[i] == CNT_MAX);
    end
  end

  // If nothing had qualified before this cycle, the qualifying pixel is the
  // one currently in S1.
  assign eval_x = cand_vld ? cand_x : s1_x;
  assign eval_y = cand_vld ? cand_y : s1_y;

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cool_nxt  = cool;
    accept    = 1'b0;
    if (frame) begin
      unique case (state)
        IDLE: state_nxt = ARMED;
        ARMED: begin
          if (|qual) begin
            accept = 1'b1;
            if (COOLDOWN_FRAMES > 0) begin
              state_nxt = COOLDOWN;
              cool_nxt  = COOL_INIT;
            end
          end
        end
        COOLDOWN: begin
          cool_nxt = cool - DW'(1);
          // The frame that ends the cooldown re-arms but is not evaluated.
          if (cool == DW'(1)) state_nxt = ARMED;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      s1_ov      <= '0;
      s1_x       <= '0;
      s1_y       <= '0;
      for (int i = 0; i < NUM_MON; i++) cnt[i] <= '0;
      cand_vld   <= 1'b0;
      cand_x     <= '0;
      cand_y     <= '0;
      cool       <= '0;
      hit        <= 1'b0;
      hit_mask   <= '0;
      hit_x      <= '0;
      hit_y      <= '0;
      invincible <= 1'b0;
      hit_count  <= '0;
    end else begin
      s1_ov      <= ov;
      s1_x       <= sx;
      s1_y       <= sy;
      cool       <= cool_nxt;
      invincible <= (state_nxt == COOLDOWN);
      hit        <= accept;
      if (accept) begin
        hit_mask <= qual;
        hit_x    <= eval_x;
        hit_y    <= eval_y;
        if (hit_count != 8'hFF) hit_count <= hit_count + 8'd1;
      end
      if (frame) begin
        for (int i = 0; i < NUM_MON; i++) cnt[i] <= '0;
        cand_vld <= 1'b0;
      end else begin
        for (int i = 0; i < NUM_MON; i++) cnt[i] <= cnt_upd[i];
        if (!cand_vld && (|qual)) begin
          cand_vld <= 1'b1;
          cand_x   <= s1_x;
          cand_y   <= s1_y;
        end
      end
    end
  end

endmodule

// File: tb/tb_sprite_collide.sv
// tb_sprite_collide: scoreboard bench for sprite_collide.
//   Stimulus plays one scan line per frame; a frame-level reference model
//   predicts hits and pushes them to a queue popped by a negedge monitor.
module tb_sprite_collide;
  localparam int CORDW = 16;
  localparam int NM    = 4;
  localparam int CB    = 4;
  localparam int MINOV = 4;
  localparam int COOL  = 2;
  localparam int W     = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst, replay, frame, de, player_drawing;
  logic signed [CORDW-1:0] sx, sy;
  logic [CB-1:0]           player_pix;
  logic [NM-1:0]           mon_drawing;
  logic [NM*CB-1:0]        mon_pix;
  logic                    hit, invincible;
  logic [NM-1:0]           hit_mask;
  logic signed [CORDW-1:0] hit_x, hit_y;
  logic [7:0]              hit_count;

  sprite_collide #(
    .CORDW(CORDW), .NUM_MON(NM), .COLR_BITS(CB), .TRANS_IDX(0),
    .MIN_OVERLAP(MINOV), .COOLDOWN_FRAMES(COOL)
  ) dut (
    .clk(clk), .rst(rst), .replay(replay), .frame(frame), .de(de),
    .sx(sx), .sy(sy), .player_drawing(player_drawing), .player_pix(player_pix),
    .mon_drawing(mon_drawing), .mon_pix(mon_pix), .hit(hit), .hit_mask(hit_mask),
    .hit_x(hit_x), .hit_y(hit_y), .invincible(invincible), .hit_count(hit_count)
  );

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  typedef struct {
    int         due;
    logic [3:0] mask;
    int         x;
    int         y;
    int         cnt;
  } exp_t;
  exp_t sb[$];

  // One scan line of stimulus per frame.
  logic        p_de [W];
  logic        p_pd [W];
  logic [3:0]  p_pp [W];
  logic [3:0]  p_md [W];
  logic [15:0] p_mp [W];
  int          p_x  [W];
  int          p_y  [W];

  // Frame-level reference state.
  bit m_armed;
  int m_cool;
  int m_hits;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_armed = 0;
    m_cool  = 0;
    m_hits  = 0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (hit === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_hit: got hit at edge %0d expected none", edge_cnt);
      end else begin
        e = sb.pop_front();
        check("hit_edge", edge_cnt, e.due);
        check("hit_mask", hit_mask, e.mask);
        check("hit_x", hit_x, e.x);
        check("hit_y", hit_y, e.y);
        check("hit_count_at_hit", hit_count, e.cnt);
      end
    end
  end

  task automatic fill_line(input int x0, input int y0);
    for (int c = 0; c < W; c++) begin
      p_de[c] = 1'b1; p_pd[c] = 1'b0; p_pp[c] = '0;
      p_md[c] = '0;   p_mp[c] = '0;
      p_x[c]  = x0 + c; p_y[c] = y0;
    end
  endtask

  task automatic put_ov(input int c, input int m, input logic [3:0] ppix,
                        input logic [3:0] mpix);
    p_pd[c] = 1'b1;
    p_pp[c] = ppix;
    p_md[c][m] = 1'b1;
    p_mp[c][m*4 +: 4] = mpix;
  endtask

  task automatic fill_random();
    fill_line(int'($urandom_range(0, 600)) - 300, int'($urandom_range(0, 500)) - 100);
    for (int c = 0; c < W; c++) begin
      p_de[c] = ($urandom_range(0, 9) != 0);
      p_pd[c] = ($urandom_range(0, 9) < 6);
      p_pp[c] = 4'($urandom_range(0, 3));
      p_md[c] = 4'($urandom_range(0, 15));
      p_mp[c] = 16'($urandom);
    end
  endtask

  // Plays the pattern, optionally pulsing rst/replay at cycle rst_at, then the
  // frame pulse. The reference counts opaque overlaps per monster with plain
  // integers and applies the frame rules.
  task automatic run_frame(input int rst_at, input bit use_replay);
    int         cnt [NM];
    bit         cand = 0;
    int         cx = 0, cy = 0;
    logic [3:0] mask = '0;
    bit         hit_exp = 0;
    foreach (cnt[i]) cnt[i] = 0;
    for (int c = 0; c < W; c++) begin
      de = p_de[c]; player_drawing = p_pd[c]; player_pix = p_pp[c];
      mon_drawing = p_md[c]; mon_pix = p_mp[c];
      sx = 16'(p_x[c]); sy = 16'(p_y[c]);
      rst = (c == rst_at) && !use_replay;
      replay = (c == rst_at) && use_replay;
      if (c == rst_at) begin
        de = 1'b0;
        model_reset();
        foreach (cnt[i]) cnt[i] = 0;
        cand = 0;
      end else if (p_de[c] && p_pd[c] && p_pp[c] != 4'd0) begin
        for (int i = 0; i < NM; i++) begin
          if (p_md[c][i] && p_mp[c][i*4 +: 4] != 4'd0) begin
            cnt[i]++;
            if (cnt[i] == MINOV && !cand) begin
              cand = 1; cx = p_x[c]; cy = p_y[c];
            end
          end
        end
      end
      @(posedge clk); #1;
      if (c == rst_at) begin
        check("rst_hit", hit, 0);
        check("rst_mask", hit_mask, 0);
        check("rst_xy", {hit_x, hit_y}, 0);
        check("rst_count", hit_count, 0);
        check("rst_invincible", invincible, 0);
      end
    end
    rst = 1'b0; replay = 1'b0; de = 1'b0; player_drawing = 1'b0; mon_drawing = '0;
    frame = 1'b1;
    for (int i = 0; i < NM; i++) mask[i] = (cnt[i] >= MINOV);
    if (!m_armed) m_armed = 1;
    else if (m_cool > 0) m_cool--;
    else if (mask != 0) begin
      hit_exp = 1;
      if (m_hits < 255) m_hits++;
      m_cool = COOL;
    end
    @(posedge clk); #1;
    frame = 1'b0;
    if (hit_exp) sb.push_back('{edge_cnt, mask, cx, cy, m_hits});
    check("invincible", invincible, m_cool > 0);
    check("hit_count", hit_count, m_hits);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; replay = 1'b0; frame = 1'b0; de = 1'b0; sx = '0; sy = '0;
    player_drawing = 1'b0; player_pix = '0; mon_drawing = '0; mon_pix = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_hit", hit, 0);
    check("reset_mask", hit_mask, 0);
    check("reset_x", hit_x, 0);
    check("reset_y", hit_y, 0);
    check("reset_invincible", invincible, 0);
    check("reset_count", hit_count, 0);
    rst = 1'b0;

    // Empty frames: first frame only arms.
    for (int f = 0; f < 3; f++) begin
      fill_line(0, 10 + f);
      run_frame(-1, 0);
    end

    // mon1 overlap at (100..103,200), the last pixel right before the frame.
    for (int f = 0; f < 4; f++) begin
      fill_line(100 - (W - 4), 200);
      for (int c = W - 4; c < W; c++) put_ov(c, 1, 4'd5, 4'd7);
      run_frame(-1, 0);
    end

    // Below threshold, and transparent monster pixels.
    for (int f = 0; f < 2; f++) begin
      fill_line(0, 20);
      run_frame(-1, 0);
    end
    fill_line(50, 30);
    for (int c = 2; c < 5; c++) put_ov(c, 2, 4'd3, 4'd9);
    run_frame(-1, 0);
    fill_line(50, 31);
    for (int c = 0; c < 10; c++) put_ov(c, 0, 4'd3, 4'd0);
    for (int c = 10; c < 16; c++) put_ov(c, 3, 4'd0, 4'd6);
    run_frame(-1, 0);

    // mon0 and mon3 both qualify; mon0 gets there first at cycle 3.
    fill_line(-40, -7);
    for (int c = 0; c < 4; c++) put_ov(c, 0, 4'd1, 4'd2);
    for (int c = 2; c < 8; c++) put_ov(c, 3, 4'd1, 4'd15);
    run_frame(-1, 0);

    // Mid-frame reset and replay after partial overlap.
    for (int f = 0; f < 2; f++) begin
      fill_line(0, 40);
      run_frame(-1, 0);
    end
    fill_line(300, 50);
    for (int c = 0; c < 3; c++) put_ov(c, 2, 4'd4, 4'd4);
    run_frame(5, 0);
    fill_line(300, 51);
    for (int c = 0; c < 6; c++) put_ov(c, 1, 4'd4, 4'd4);
    run_frame(8, 1);
    fill_line(300, 52);
    for (int c = 0; c < 6; c++) put_ov(c, 1, 4'd4, 4'd4);
    run_frame(-1, 0);

    for (int f = 0; f < 40; f++) begin
      fill_random();
      run_frame(-1, 0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
